irq_sched: RTL and testbench

Interrupt scheduler between peripheral interrupt sources and the pipelined MIPS CPU's single `interrupt` input.
- Latches request edges from up to `N_SRC` devices and applies a configurable enable mask.
- Grants one source at a time by fixed priority and drives the CPU line with a bounded hold/retry protocol.
- Presents the granted source as a one-hot vector for the CP0 Cause.IP field.
- Blocks further grants until the handler signals end-of-interrupt.

---
 rtl/irq_sched.sv | 129 ++++++++++++
 tb/tb_irq_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Interrupt scheduler: latches request edges, masks them, grants one source by
// fixed priority (highest index) and drives the CPU interrupt line with hold/retry.

module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pending
);
  logic req_q;

  // A fresh edge beats a same-cycle clear so that no request is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr) | (req & ~req_q);
    end
  end
endmodule

module irq_sched #(
  parameter int N_SRC       = 6,
  parameter int HOLD_CYCLES = 6,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             interrupt,
  output logic [N_SRC-1:0] hwint,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             busy,
  output logic [CNT_W-1:0] retry_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE, S_GAP} state_t;

  state_t           state;
  logic [N_SRC-1:0] grant;
  logic [HW-1:0]    hold_cnt;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] win;
  logic [N_SRC-1:0] pend_clr;

  assign pend_clr = (state == S_ASSERT && ack) ? grant : '0;
  assign elig     = pending & mask;
  assign busy     = (state != S_IDLE);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_src_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .req     (req[i]),
      .clr     (pend_clr[i]),
      .pending (pending[i])
    );
  end

  // Ascending scan: the last (highest) eligible index overwrites earlier ones.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant     <= '0;
      hold_cnt  <= '0;
      interrupt <= 1'b0;
      hwint     <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (elig != '0) begin
            state     <= S_ASSERT;
            grant     <= win;
            hwint     <= win;
            hold_cnt  <= HW'(HOLD_CYCLES - 1);
            interrupt <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state     <= S_SERVICE;
            interrupt <= 1'b0;
          end else if (hold_cnt == '0) begin
            state     <= S_GAP;
            interrupt <= 1'b0;
            hwint     <= '0;
            grant     <= '0;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            state <= S_IDLE;
            grant <= '0;
            hwint <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: cycle vector table plus timeout and async-reset sequences.

module tb_irq_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req, mask_wdata;
  logic       mask_we, ack, eoi;
  logic       interrupt, busy;
  logic [5:0] hwint, pending, mask;
  logic [7:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_sched dut (
    .clk(clk), .reset(reset), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ack(ack), .eoi(eoi), .interrupt(interrupt), .hwint(hwint), .pending(pending),
    .mask(mask), .busy(busy), .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic [5:0] req;
    logic       we;
    logic [5:0] wd;
    logic       ack, eoi;
    logic       e_int;
    logic [5:0] e_hw, e_pend, e_mask;
    logic       e_busy;
    logic [7:0] e_retry;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic [5:0] r, logic w, logic [5:0] d, logic a, logic e,
                             logic ei, logic [5:0] eh, logic [5:0] ep, logic [5:0] em,
                             logic eb, logic [7:0] er);
    vec_t t;
    t = '{r, w, d, a, e, ei, eh, ep, em, eb, er};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ei, input logic [5:0] eh,
                         input logic [5:0] ep, input logic [5:0] em, input logic eb,
                         input logic [7:0] er);
    chk({tag, ".int"},   32'(interrupt), 32'(ei));
    chk({tag, ".hwint"}, 32'(hwint),     32'(eh));
    chk({tag, ".pend"},  32'(pending),   32'(ep));
    chk({tag, ".mask"},  32'(mask),      32'(em));
    chk({tag, ".busy"},  32'(busy),      32'(eb));
    chk({tag, ".retry"}, 32'(retry_cnt), 32'(er));
  endtask

  // Drive one cycle of inputs, let the edge sample them, settle past the edge.
  task automatic step(input logic [5:0] r, input logic w, input logic [5:0] d,
                      input logic a, input logic e);
    req = r; mask_we = w; mask_wdata = d; ack = a; eoi = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 6'h00, 6'h00, 6'h3f, 1'b0, 8'd0);
    reset = 1'b1;

    // single request on source 2
    tv.push_back(v(6'h04,0,6'h00,0,0, 0,6'h00,6'h04,6'h3f,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h04,6'h04,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h04,6'h04,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h04,6'h04,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,1,0, 0,6'h04,6'h00,6'h3f,1,0));
    for (int k = 0; k < 4; k++)
      tv.push_back(v(6'h00,0,6'h00,0,0, 0,6'h04,6'h00,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,1, 0,6'h00,6'h00,6'h3f,0,0));
    // priority: sources 1 and 4 together
    tv.push_back(v(6'h12,0,6'h00,0,0, 0,6'h00,6'h12,6'h3f,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h10,6'h12,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,1,0, 0,6'h10,6'h02,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,1, 0,6'h00,6'h02,6'h3f,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h02,6'h02,6'h3f,1,0));
    // no preemption: source 5 edge during service of source 1
    tv.push_back(v(6'h00,0,6'h00,1,0, 0,6'h02,6'h00,6'h3f,1,0));
    tv.push_back(v(6'h20,0,6'h00,0,0, 0,6'h02,6'h20,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 0,6'h02,6'h20,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,1, 0,6'h00,6'h20,6'h3f,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h20,6'h20,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,1,0, 0,6'h20,6'h00,6'h3f,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,1, 0,6'h00,6'h00,6'h3f,0,0));
    // stray ack/eoi in IDLE
    tv.push_back(v(6'h00,0,6'h00,1,1, 0,6'h00,6'h00,6'h3f,0,0));
    // mask source 0, request it, then unmask
    tv.push_back(v(6'h00,1,6'h3e,0,0, 0,6'h00,6'h00,6'h3e,0,0));
    tv.push_back(v(6'h01,0,6'h00,0,0, 0,6'h00,6'h01,6'h3e,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 0,6'h00,6'h01,6'h3e,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 0,6'h00,6'h01,6'h3e,0,0));
    tv.push_back(v(6'h00,1,6'h3f,0,0, 0,6'h00,6'h01,6'h3f,0,0));
    tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h01,6'h01,6'h3f,1,0));
    // masking the granted source does not cancel it; ack lands on the last hold cycle
    tv.push_back(v(6'h00,1,6'h00,0,0, 1,6'h01,6'h01,6'h00,1,0));
    for (int k = 0; k < 4; k++)
      tv.push_back(v(6'h00,0,6'h00,0,0, 1,6'h01,6'h01,6'h00,1,0));
    tv.push_back(v(6'h00,0,6'h00,1,0, 0,6'h01,6'h00,6'h00,1,0));
    tv.push_back(v(6'h00,0,6'h00,0,1, 0,6'h00,6'h00,6'h00,0,0));
    tv.push_back(v(6'h00,1,6'h3f,0,0, 0,6'h00,6'h00,6'h3f,0,0));

    foreach (tv[i]) begin
      step(tv[i].req, tv[i].we, tv[i].wd, tv[i].ack, tv[i].eoi);
      chk_all($sformatf("row%0d", i), tv[i].e_int, tv[i].e_hw, tv[i].e_pend,
              tv[i].e_mask, tv[i].e_busy, tv[i].e_retry);
    end

    // timeout/retry: 6 high, 2 low, 6 high, retry counts up, pending held
    step(6'h01, 0, 6'h00, 0, 0);
    chk("to.pend0", 32'(pending), 32'h01);
    for (int c = 0; c < 16; c++) begin
      logic       ei;
      logic [7:0] er;
      step(6'h00, 0, 6'h00, 0, 0);
      ei = ((c % 8) < 6);
      er = (c >= 14) ? 8'd2 : (c >= 6) ? 8'd1 : 8'd0;
      chk_all($sformatf("to.c%0d", c), ei, ei ? 6'h01 : 6'h00, 6'h01, 6'h3f, (c % 8) != 7, er);
    end
    step(6'h00, 0, 6'h00, 0, 0);
    chk("to.reassert", 32'(interrupt), 32'h1);
    step(6'h00, 0, 6'h00, 1, 0);
    chk_all("to.ack", 1'b0, 6'h01, 6'h00, 6'h3f, 1'b1, 8'd2);
    step(6'h00, 0, 6'h00, 0, 1);
    chk_all("to.eoi", 1'b0, 6'h00, 6'h00, 6'h3f, 1'b0, 8'd2);

    // async reset mid-ASSERT with req[3] held high throughout
    step(6'h08, 0, 6'h00, 0, 0);
    step(6'h08, 1, 6'h00, 0, 0);
    chk_all("rs.pre", 1'b1, 6'h08, 6'h08, 6'h00, 1'b1, 8'd2);
    #2 reset = 1'b0;
    #1;
    chk_all("rs.async", 1'b0, 6'h00, 6'h00, 6'h3f, 1'b0, 8'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(6'h08, 0, 6'h00, 0, 0);
    chk_all("rs.edge", 1'b0, 6'h00, 6'h08, 6'h3f, 1'b0, 8'd0);
    step(6'h08, 0, 6'h00, 0, 0);
    chk_all("rs.grant", 1'b1, 6'h08, 6'h08, 6'h3f, 1'b1, 8'd0);
    step(6'h08, 0, 6'h00, 1, 0);
    chk_all("rs.ack", 1'b0, 6'h08, 6'h00, 6'h3f, 1'b1, 8'd0);
    step(6'h08, 0, 6'h00, 0, 1);
    chk_all("rs.eoi", 1'b0, 6'h00, 6'h00, 6'h3f, 1'b0, 8'd0);
    step(6'h08, 0, 6'h00, 0, 0);
    chk_all("rs.once", 1'b0, 6'h00, 6'h00, 6'h3f, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
